peripheral_wb_arbiter: RTL and testbench
========================================

PERIPHERAL_WB_ARBITER -- requirements
Module: peripheral_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of Wishbone requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 256, max cycles awaiting slave response; 0 disables the watchdog.
REQ-003 SHALL take AW (32) and DW (32) from peripheral_bb_pkg; select width is DW/8.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 m_adr_i  in  NUM_MASTERS*AW  packed master addresses, master k at slice k.
REQ-007 m_dat_i  in  NUM_MASTERS*DW  packed master write data.
REQ-008 m_sel_i  in  NUM_MASTERS*DW/8  packed byte selects.
REQ-009 m_we_i, m_stb_i, m_cyc_i  in  NUM_MASTERS each  per-master write enable, strobe, cycle.
REQ-010 m_dat_o  out  DW  slave read data broadcast to all masters.
REQ-011 m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master responses.
REQ-012 s_adr_o  out  AW;  s_dat_o  out  DW;  s_sel_o  out  DW/8;  s_we_o, s_stb_o, s_cyc_o  out  1  shared slave request.
REQ-013 s_dat_i  in  DW;  s_ack_i, s_err_i, s_rty_i  in  1  slave response.
REQ-014 grant_o  out  NUM_MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, TOUT.
REQ-016 IDLE: any m_cyc_i high -> register grant to first requester searching upward (with wrap) from last_owner+1; enter BUSY next cycle (1-cycle arbitration latency).
REQ-017 IDLE: s_cyc_o, s_stb_o, all m_ack_o/m_err_o/m_rty_o SHALL be 0.
REQ-018 BUSY: s_adr_o/s_dat_o/s_sel_o/s_we_o/s_stb_o/s_cyc_o SHALL combinationally mirror the granted master's inputs.
REQ-019 BUSY: s_ack_i/s_err_i/s_rty_i SHALL route combinationally to the granted master only; other masters see 0.
REQ-020 Grant SHALL hold for the whole bus cycle (burst-safe) while the granted m_cyc_i stays high, regardless of other requests.
REQ-021 Granted m_cyc_i low in BUSY -> IDLE next cycle, last_owner := granted index, grant_o cleared.
REQ-022 Watchdog counter SHALL increment each BUSY cycle with s_stb_o=1 and no slave response; clear on any response, on stb low, and on leaving BUSY.
REQ-023 Counter reaching TIMEOUT-1 with no response (TIMEOUT!=0) -> enter TOUT next cycle.
REQ-024 TOUT: s_cyc_o=s_stb_o=0; m_err_o of owner SHALL pulse 1 for exactly the first TOUT cycle; stay in TOUT until owner drops m_cyc_i, then IDLE with last_owner updated.
REQ-025 Late slave response during TOUT SHALL be discarded.
REQ-026 Counter width SHALL be $clog2(TIMEOUT+1), saturating, never wrapping.
REQ-027 Simultaneous requests SHALL be resolved by round-robin only; no master starves beyond NUM_MASTERS-1 foreign bus cycles.
REQ-028 m_dat_o SHALL equal s_dat_i at all times.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, grant 0, counter 0, last_owner NUM_MASTERS-1 (master 0 wins first).
REQ-030 Reset mid-transfer SHALL immediately drop s_cyc_o/s_stb_o and all m_*_o responses to 0.

Structure
REQ-031 AW, DW and an FSM state enum SHALL live in peripheral_bb_pkg; arbiter imports it.
REQ-032 Round-robin selection SHALL be a sub-module peripheral_wb_rr_arbiter (request vector, last_owner in; one-hot grant out, combinational).

Verification
REQ-033 After reset, m_cyc_i=4'b0101 same cycle -> grant_o=4'b0001 after 1 cycle; after master 0 releases, grant_o=4'b0100.
REQ-034 All four request continuously, 1-beat cycles -> grant order 0,1,2,3,0; each master granted once per 4 bus cycles.
REQ-035 Master 1 holds cyc for 8-beat burst with stb gaps while master 2 requests -> grant_o stays 4'b0010 all 8 acks; master 2 granted after release.
REQ-036 TIMEOUT=16, slave never responds -> s_cyc_o low in 17th stb cycle, m_err_o[owner] one-cycle pulse, no ack to anyone.
REQ-037 s_err_i and s_rty_i single cycles -> routed only to owner's m_err_o/m_rty_o; watchdog cleared.
REQ-038 rst_n low mid-burst -> s_cyc_o=0 same cycle; after release, master 0 wins first arbitration.

Source files
------------

// File: rtl/peripheral_bb_pkg.sv
// Shared bus widths and arbiter state encoding for the peripheral Wishbone fabric.
package peripheral_bb_pkg;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/peripheral_wb_rr_arbiter.sv
// Combinational round-robin picker: first requester searching upward (with wrap)
// from last_owner+1, returned both one-hot and as an index.
module peripheral_wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last_owner,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IW-1:0]          grant_idx
);

    logic found;
    int   cand;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(last_owner) + i;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/peripheral_wb_arbiter.sv
// Multi-master Wishbone arbiter: round-robin ownership held for a whole bus cycle,
// combinational request/response routing, and a watchdog that errors a stalled owner.
module peripheral_wb_arbiter
    import peripheral_bb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [SW-1:0]             s_sel_o,
    output logic                      s_we_o,
    output logic                      s_stb_o,
    output logic                      s_cyc_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          last_owner;
    logic [CW-1:0]          wd_cnt;
    logic                   err_first;

    logic [NUM_MASTERS-1:0] rr_grant;
    logic [IW-1:0]          rr_idx;

    logic busy;
    logic own_cyc;
    logic own_stb;
    logic slv_resp;
    logic wd_timeout;

    peripheral_wb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_rr (
        .req        (m_cyc_i),
        .last_owner (last_owner),
        .grant      (rr_grant),
        .grant_idx  (rr_idx)
    );

    assign busy       = (state == BUSY);
    assign own_cyc    = m_cyc_i[owner];
    assign own_stb    = m_stb_i[owner];
    assign slv_resp   = s_ack_i | s_err_i | s_rty_i;
    assign wd_timeout = (TIMEOUT != 0) && own_stb && !slv_resp && (wd_cnt == CNT_LAST);

    // Request path mirrors the owner only while BUSY; reset forces IDLE, so it drops at once.
    assign s_cyc_o = busy & own_cyc;
    assign s_stb_o = busy & own_stb;
    assign s_we_o  = busy & m_we_i[owner];
    assign s_adr_o = busy ? m_adr_i[int'(owner)*AW +: AW] : '0;
    assign s_dat_o = busy ? m_dat_i[int'(owner)*DW +: DW] : '0;
    assign s_sel_o = busy ? m_sel_i[int'(owner)*SW +: SW] : '0;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant_q & {NUM_MASTERS{busy & s_ack_i}};
    assign m_rty_o = grant_q & {NUM_MASTERS{busy & s_rty_i}};
    assign m_err_o = grant_q & {NUM_MASTERS{(busy & s_err_i) | ((state == TOUT) & err_first)}};
    assign grant_o = grant_q;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            owner      <= '0;
            last_owner <= IW'(NUM_MASTERS - 1);
            wd_cnt     <= '0;
            err_first  <= 1'b0;
        end else begin
            err_first <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|m_cyc_i) begin
                        grant_q <= rr_grant;
                        owner   <= rr_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state      <= IDLE;
                        grant_q    <= '0;
                        last_owner <= owner;
                        wd_cnt     <= '0;
                    end else if (wd_timeout) begin
                        state     <= TOUT;
                        err_first <= 1'b1;
                        wd_cnt    <= '0;
                    end else if (own_stb && !slv_resp) begin
                        if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                TOUT: begin
                    wd_cnt <= '0;
                    if (!own_cyc) begin
                        state      <= IDLE;
                        grant_q    <= '0;
                        last_owner <= owner;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    wd_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_wb_arbiter.sv
// Self-checking bench for peripheral_wb_arbiter: directed vector table, hand-written
// burst / watchdog / reset sequences, and randomized traffic against a reference model.
module tb_peripheral_wb_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [N-1:0]      m_we_i, m_stb_i, m_cyc_i;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o, s_stb_o, s_cyc_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]      grant_o;

    always #5 clk = ~clk;

    peripheral_wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] adr_of(input int k);
        return 32'hA000_0000 + AW'(k);
    endfunction

    task automatic clear_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        s_dat_i = '0;
        for (int k = 0; k < N; k++) begin
            m_adr_i[k*AW +: AW] = adr_of(k);
            m_dat_i[k*DW +: DW] = 32'hD000_0000 + DW'(k);
            m_sel_i[k*SW +: SW] = SW'(k + 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Reference model: owner index (-1 = free), previous owner, consecutive unanswered strobes.
    int mo_owner, mo_last, mo_wait;
    bit mo_tout, mo_first;

    task automatic model_reset();
        mo_owner = -1; mo_last = N - 1; mo_wait = 0; mo_tout = 0; mo_first = 0;
    endtask

    task automatic model_edge();
        bit resp;
        resp = s_ack_i | s_err_i | s_rty_i;
        mo_first = 0;
        if (mo_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (mo_owner < 0 && m_cyc_i[(mo_last + k) % N]) mo_owner = (mo_last + k) % N;
            end
            mo_wait = 0;
        end else if (!m_cyc_i[mo_owner]) begin
            mo_last = mo_owner; mo_owner = -1; mo_tout = 0; mo_wait = 0;
        end else if (!mo_tout) begin
            if (m_stb_i[mo_owner] && !resp) begin
                mo_wait++;
                if (mo_wait == TO) begin
                    mo_tout = 1; mo_first = 1; mo_wait = 0;
                end
            end else begin
                mo_wait = 0;
            end
        end
    endtask

    task automatic model_check();
        logic [N-1:0] oh;
        logic [38:0]  exp_req;
        logic [DW-1:0] exp_dat;
        logic [3*N-1:0] exp_resp;
        bit busy;
        oh = '0;
        if (mo_owner >= 0) oh[mo_owner] = 1'b1;
        busy = (mo_owner >= 0) && !mo_tout;
        exp_req = '0;
        exp_dat = '0;
        if (busy) begin
            exp_req = {m_cyc_i[mo_owner], m_stb_i[mo_owner], m_we_i[mo_owner],
                       m_sel_i[mo_owner*SW +: SW], m_adr_i[mo_owner*AW +: AW]};
            exp_dat = m_dat_i[mo_owner*DW +: DW];
        end
        exp_resp = {(busy && s_ack_i) ? oh : '0,
                    ((busy && s_err_i) || (mo_tout && mo_first)) ? oh : '0,
                    (busy && s_rty_i) ? oh : '0};
        check("rand_grant", grant_o, oh);
        check("rand_req", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}, exp_req);
        check("rand_wdat", s_dat_o, exp_dat);
        check("rand_resp", {m_ack_o, m_err_o, m_rty_o}, exp_resp);
        check("rand_rdat", m_dat_o, s_dat_i);
    endtask

    typedef struct {
        logic [N-1:0] cyc;
        logic [N-1:0] stb;
        logic         ack, err, rty;
        logic [N-1:0] e_grant, e_ack, e_err, e_rty;
        logic         e_scyc;
        int           e_src;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        // cyc    stb    ack  err  rty   grant  ack    err    rty    scyc src
        tbl[0]  = '{4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, -1};
        tbl[1]  = '{4'b0101, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, -1};
        tbl[2]  = '{4'b0101, 4'b0101, 1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1,  0};
        tbl[3]  = '{4'b0100, 4'b0100, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0,  0};
        tbl[4]  = '{4'b0100, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, -1};
        tbl[5]  = '{4'b0100, 4'b0100, 0, 1, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1,  2};
        tbl[6]  = '{4'b0100, 4'b0100, 0, 0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1,  2};
        tbl[7]  = '{4'b0110, 4'b0110, 1, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1,  2};
        tbl[8]  = '{4'b0010, 4'b0010, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0,  2};
        tbl[9]  = '{4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, -1};
        tbl[10] = '{4'b0010, 4'b0010, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1,  1};
        tbl[11] = '{4'b0000, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0,  1};
        tbl[12] = '{4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, -1};

        // Directed vectors: first arbitration, response routing, release handover.
        do_reset();
        #1;
        check("reset_grant", grant_o, 4'b0000);
        check("reset_scyc", s_cyc_o, 1'b0);
        for (int r = 0; r < 13; r++) begin
            m_cyc_i = tbl[r].cyc; m_stb_i = tbl[r].stb;
            s_ack_i = tbl[r].ack; s_err_i = tbl[r].err; s_rty_i = tbl[r].rty;
            s_dat_i = $urandom;
            #2;
            check($sformatf("vec%0d_grant", r), grant_o, tbl[r].e_grant);
            check($sformatf("vec%0d_ack", r), m_ack_o, tbl[r].e_ack);
            check($sformatf("vec%0d_err", r), m_err_o, tbl[r].e_err);
            check($sformatf("vec%0d_rty", r), m_rty_o, tbl[r].e_rty);
            check($sformatf("vec%0d_scyc", r), {s_cyc_o, s_stb_o}, {tbl[r].e_scyc, tbl[r].e_scyc});
            check($sformatf("vec%0d_sadr", r), s_adr_o, (tbl[r].e_src < 0) ? '0 : adr_of(tbl[r].e_src));
            check($sformatf("vec%0d_mdat", r), m_dat_o, s_dat_i);
            next_cycle();
        end

        // All four request continuously with single-beat cycles: strict rotation.
        begin
            logic [N-1:0] drop, prev_g;
            int order[$];
            int exp_order[5];
            exp_order = '{0, 1, 2, 3, 0};
            do_reset();
            drop = '0; prev_g = '0;
            for (int c = 0; c < 60 && order.size() < 5; c++) begin
                m_cyc_i = ~drop; m_stb_i = ~drop; s_ack_i = 1'b1;
                #2;
                if (prev_g == '0 && grant_o != '0) order.push_back(onehot_idx(grant_o));
                prev_g = grant_o;
                drop = m_ack_o;
                next_cycle();
            end
            check("rr_count", order.size(), 5);
            for (int i = 0; i < 5; i++)
                check($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);
        end

        // Master 1 burst with strobe gaps while master 2 waits.
        begin
            int acks, c, waited;
            do_reset();
            m_cyc_i = 4'b0110;
            acks = 0; c = 0;
            while (acks < 8 && c < 100) begin
                m_stb_i = {1'b0, 1'b1, (c % 3) != 2, 1'b0};
                #1 s_ack_i = s_stb_o;
                #1;
                if (c >= 1) check("burst_grant", grant_o, 4'b0010);
                check("burst_no_ack2", m_ack_o[2], 1'b0);
                if (m_ack_o[1]) acks++;
                c++;
                next_cycle();
            end
            check("burst_acks", acks, 8);
            m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; s_ack_i = 1'b0;
            waited = 0;
            do begin
                next_cycle();
                #1;
                waited++;
            end while (grant_o != 4'b0100 && waited < 6);
            check("burst_next_grant", grant_o, 4'b0100);
        end

        // Watchdog: cleared by a retry, then times out after 16 silent strobes.
        do_reset();
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        for (int j = 0; j <= 31; j++) begin
            s_rty_i = (j == 11);
            s_ack_i = (j == 29);
            if (j >= 30) begin m_cyc_i = '0; m_stb_i = '0; end
            #2;
            check($sformatf("wd%0d_scyc", j), s_cyc_o, (j >= 1 && j <= 27));
            check($sformatf("wd%0d_err", j), m_err_o, (j == 28) ? 4'b1000 : 4'b0000);
            check($sformatf("wd%0d_ack", j), m_ack_o, 4'b0000);
            check($sformatf("wd%0d_rty", j), m_rty_o, (j == 11) ? 4'b1000 : 4'b0000);
            check($sformatf("wd%0d_grant", j), grant_o, (j >= 1 && j <= 30) ? 4'b1000 : 4'b0000);
            next_cycle();
        end
        s_ack_i = 1'b0; s_rty_i = 1'b0;

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
        next_cycle();
        s_ack_i = 1'b1;
        #2;
        check("rst_pre_scyc", s_cyc_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_scyc", {s_cyc_o, s_stb_o}, 2'b00);
        check("rst_grant", grant_o, 4'b0000);
        check("rst_ack", m_ack_o, 4'b0000);
        next_cycle();
        rst_n = 1'b1;
        m_cyc_i = 4'b0101; m_stb_i = 4'b0101; s_ack_i = 1'b0;
        #2;
        check("rst_idle_grant", grant_o, 4'b0000);
        next_cycle();
        #1;
        check("rst_first_grant", grant_o, 4'b0001);

        // Randomized traffic with silent-slave windows, against the reference model.
        begin
            int silent;
            do_reset();
            model_reset();
            silent = 0;
            for (int c = 0; c < 1500; c++) begin
                if (silent == 0 && $urandom_range(99) == 0) begin
                    silent = 24;
                    m_cyc_i[$urandom_range(N-1)] = 1'b1;
                end
                for (int k = 0; k < N; k++) begin
                    if (silent == 0 && $urandom_range(7) == 0) m_cyc_i[k] = ~m_cyc_i[k];
                    m_stb_i[k] = m_cyc_i[k] & ((silent != 0) || ($urandom_range(3) != 0));
                    m_we_i[k]  = $urandom_range(1);
                    m_adr_i[k*AW +: AW] = $urandom;
                    m_dat_i[k*DW +: DW] = $urandom;
                    m_sel_i[k*SW +: SW] = SW'($urandom);
                end
                s_dat_i = $urandom;
                s_ack_i = (silent == 0) && ($urandom_range(1) == 1);
                s_err_i = (silent == 0) && ($urandom_range(15) == 0);
                s_rty_i = (silent == 0) && ($urandom_range(15) == 0);
                if (silent > 0) silent--;
                #2;
                model_check();
                model_edge();
                next_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
